// File: rtl/seq_pkg.sv
// Shared types and helpers for the memory-game sequence player.
// Symbol k of a ROM row is stored MSB-first: row[29-3k -: 3].
package seq_pkg;

   localparam int SYM_W   = 3;
   localparam int NUM_SYM = 10;
   localparam int ROW_W   = SYM_W * NUM_SYM;
   localparam int IDX_W   = 4;

   localparam logic [SYM_W-1:0] SYM_NONE = '0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHOW_ON,
      SHOW_GAP,
      INPUT,
      RESULT
   } state_t;

   // Constant-index mux keeps every slice in range for any k.
   function automatic logic [SYM_W-1:0] get_sym(input logic [ROW_W-1:0] row,
                                                input logic [IDX_W-1:0] k);
      get_sym = SYM_NONE;
      for (int i = 0; i < NUM_SYM; i++) begin
         if (k == IDX_W'(i))
            get_sym = row[ROW_W-1-SYM_W*i -: SYM_W];
      end
   endfunction

   function automatic logic [IDX_W-1:0] clamp_level(input logic [IDX_W-1:0] lv);
      if (lv == '0)
         clamp_level = IDX_W'(1);
      else if (lv > IDX_W'(NUM_SYM))
         clamp_level = IDX_W'(NUM_SYM);
      else
         clamp_level = lv;
   endfunction

endpackage

// File: rtl/seq_cycle_timer.sv
// Loadable down-counter with a one-cycle expire pulse on the last counted cycle.
// Loading N makes expire fire N-1 cycles after the load edge, so a state entered
// on the load edge lasts exactly N cycles.
module seq_cycle_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   // Must not depend on load: the FSM reloads in the same cycle it sees expire.
   assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/seq_player_ctrl.sv
// Plays a ROM pattern row on the display, then checks the player's presses.
// Optional build macro SEQ_TIMEOUT_EN: fail the round if no press arrives in TIMEOUT_CYC.
module seq_player_ctrl
   import seq_pkg::*;
#(
   parameter int ON_CYC      = 25000000,
   parameter int GAP_CYC     = 12500000,
   parameter int TIMEOUT_CYC = 250000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       pattern,
   input  logic [3:0]       level,
   output logic [3:0]       rom_dir,
   input  logic [ROW_W-1:0] rom_dato,
   output logic [SYM_W-1:0] show_sym,
   input  logic             btn_valid,
   input  logic [SYM_W-1:0] btn_sym,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail
);

   localparam int MAX_A  = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
   localparam int MAX_CYC = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
   localparam int CNT_W  = $clog2(MAX_CYC + 1);

   state_t           state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [IDX_W-1:0] lvl_q;
   logic [ROW_W-1:0] seq_q;
   logic             fetch_cnt;
   logic             accept, set_pass, set_fail;
   logic             tmr_load, tmr_exp;
   logic [CNT_W-1:0] tmr_val;
   logic             last_idx;

   seq_cycle_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_exp)
   );

   assign last_idx = (idx == lvl_q - IDX_W'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx       <= '0;
         lvl_q     <= '0;
         seq_q     <= '0;
         fetch_cnt <= 1'b0;
         rom_dir   <= '0;
         pass      <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         fetch_cnt <= (state == FETCH) ? ~fetch_cnt : 1'b0;
         if (accept) begin
            rom_dir <= pattern;
            lvl_q   <= clamp_level(level);
            pass    <= 1'b0;
            fail    <= 1'b0;
         end
         // Row is frozen here for the rest of the round.
         if (state == FETCH && fetch_cnt)
            seq_q <= rom_dato;
         if (set_pass)
            pass <= 1'b1;
         if (set_fail)
            fail <= 1'b1;
      end
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      accept   = 1'b0;
      set_pass = 1'b0;
      set_fail = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_n = FETCH;
            end
         end
         FETCH: begin
            if (fetch_cnt) begin
               state_n  = SHOW_ON;
               idx_n    = '0;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(ON_CYC);
            end
         end
         SHOW_ON: begin
            if (tmr_exp) begin
               state_n  = SHOW_GAP;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(GAP_CYC);
            end
         end
         SHOW_GAP: begin
            if (tmr_exp) begin
               if (last_idx) begin
                  state_n = INPUT;
                  idx_n   = '0;
`ifdef SEQ_TIMEOUT_EN
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(TIMEOUT_CYC);
`endif
               end else begin
                  state_n  = SHOW_ON;
                  idx_n    = idx + IDX_W'(1);
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(ON_CYC);
               end
            end
         end
         INPUT: begin
            if (btn_valid) begin
               if (btn_sym != get_sym(seq_q, idx)) begin
                  state_n  = RESULT;
                  set_fail = 1'b1;
               end else if (last_idx) begin
                  state_n  = RESULT;
                  set_pass = 1'b1;
               end else begin
                  idx_n = idx + IDX_W'(1);
`ifdef SEQ_TIMEOUT_EN
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(TIMEOUT_CYC);
`endif
               end
            end
`ifdef SEQ_TIMEOUT_EN
            else if (tmr_exp) begin
               state_n  = RESULT;
               set_fail = 1'b1;
            end
`endif
         end
         RESULT: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy     = (state != IDLE) && (state != RESULT);
   assign done     = (state == RESULT);
   assign show_sym = (state == SHOW_ON) ? get_sym(seq_q, idx) : SYM_NONE;

endmodule
